// File: rtl/fft_ctrl_pkg.sv
// Shared fixed-point definitions and default FFT geometry for the FFT controller.
`default_nettype none
package fft_ctrl_pkg;
  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = $clog2(FFT_N);

  // Q1.(R) sample format: R fractional bits in a DATA_W-bit signed word.
  localparam int DATA_W = 16;
  localparam int R      = 14;
  localparam logic signed [DATA_W-1:0] FIXED_POINT_MAX = 16'sh7fff;
  localparam logic signed [DATA_W-1:0] FIXED_POINT_MIN = 16'sh8000;

  typedef struct packed {
    logic signed [2*DATA_W-1:0] re;
    logic signed [2*DATA_W-1:0] im;
  } complex_product_t;
endpackage
`default_nettype wire

// File: rtl/fft_addr_gen.sv
// Radix-2 DIF operand addresses and twiddle index for butterfly k of a stage.
`default_nettype none
module fft_addr_gen
  import fft_ctrl_pkg::*;
#(
  parameter int N = FFT_N
) (
  input  logic [$clog2(N)-1:0] stage,
  input  logic [$clog2(N)-2:0] k,
  output logic [$clog2(N)-1:0] addr_a,
  output logic [$clog2(N)-1:0] addr_b,
  output logic [$clog2(N)-2:0] tw_idx
);
  localparam int LOG2N = $clog2(N);
  localparam int AW    = LOG2N;

  int            sh;
  logic [AW-1:0] span;
  logic [AW-1:0] mask;
  logic [AW-1:0] k_ext;
  logic [AW-1:0] j;

  // span is a power of two, so k/span and k%span reduce to masking.
  always_comb begin
    sh     = int'(stage) + 1;
    span   = AW'(N >> sh);
    mask   = span - AW'(1);
    k_ext  = AW'(k);
    j      = k_ext & mask;
    addr_a = ((k_ext & ~mask) << 1) | j;
    addr_b = addr_a | span;
    tw_idx = (LOG2N-1)'(j << stage);
  end
endmodule
`default_nettype wire

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIF FFT sequencer: issues N/2 butterflies per stage, drains the
// butterfly pipeline between stages, and delays write-back addresses by BF_LAT.
`default_nettype none
module fft_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int BF_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 bf_enable,
  output logic [$clog2(N)-1:0] rd_addr_a,
  output logic [$clog2(N)-1:0] rd_addr_b,
  output logic [$clog2(N)-2:0] tw_idx,
  output logic                 wr_en,
  output logic [$clog2(N)-1:0] wr_addr_a,
  output logic [$clog2(N)-1:0] wr_addr_b,
  output logic [$clog2(N)-1:0] stage,
  output logic                 busy,
  output logic                 done
);
  localparam int LOG2N = $clog2(N);
  localparam int AW    = LOG2N;
  localparam int KW    = LOG2N - 1;

  localparam logic [KW-1:0]    K_LAST = KW'(N/2 - 1);
  localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);
  localparam logic [2:0]       D_LAST = 3'(BF_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic [LOG2N-1:0] stage_q, stage_n;
  logic [KW-1:0]    k_q, k_n;
  logic [2:0]       dcnt_q, dcnt_n;

  logic [AW-1:0]    gen_a, gen_b;
  logic [KW-1:0]    gen_tw;

  logic [BF_LAT-1:0] en_pipe;
  logic [AW-1:0]     a_pipe [BF_LAT];
  logic [AW-1:0]     b_pipe [BF_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      stage_q <= '0;
      k_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state   <= state_n;
      stage_q <= stage_n;
      k_q     <= k_n;
      dcnt_q  <= dcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    stage_n = stage_q;
    k_n     = k_q;
    dcnt_n  = dcnt_q;
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        stage_n = '0;
        k_n     = '0;
      end
      RUN: if (k_q == K_LAST) begin
        state_n = DRAIN;
        dcnt_n  = '0;
      end else begin
        k_n = k_q + KW'(1);
      end
      // The last write of a stage lands before the first read of the next one.
      DRAIN: if (dcnt_q == D_LAST) begin
        if (stage_q < S_LAST) begin
          state_n = RUN;
          stage_n = stage_q + LOG2N'(1);
          k_n     = '0;
        end else begin
          state_n = DONE;
        end
      end else begin
        dcnt_n = dcnt_q + 3'd1;
      end
      DONE: begin
        state_n = IDLE;
        stage_n = '0;
        k_n     = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  fft_addr_gen #(.N(N)) u_addr_gen (
    .stage  (stage_q),
    .k      (k_q),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  assign bf_enable = (state == RUN);
  assign rd_addr_a = bf_enable ? gen_a  : '0;
  assign rd_addr_b = bf_enable ? gen_b  : '0;
  assign tw_idx    = bf_enable ? gen_tw : '0;
  assign stage     = stage_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      en_pipe <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      en_pipe[0] <= bf_enable;
      a_pipe[0]  <= rd_addr_a;
      b_pipe[0]  <= rd_addr_b;
      for (int i = 1; i < BF_LAT; i++) begin
        en_pipe[i] <= en_pipe[i-1];
        a_pipe[i]  <= a_pipe[i-1];
        b_pipe[i]  <= b_pipe[i-1];
      end
    end
  end

  assign wr_en     = en_pipe[BF_LAT-1];
  assign wr_addr_a = a_pipe[BF_LAT-1];
  assign wr_addr_b = b_pipe[BF_LAT-1];
endmodule
`default_nettype wire

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: cycle model, write-address scoreboard and
// an in-place memory/butterfly model for an impulse transform.
`default_nettype none
module tb_fft_ctrl;
  localparam int N      = 16;
  localparam int BF_LAT = 1;
  localparam int LOG2N  = 4;
  localparam int LAST   = 1 + LOG2N * (N/2 + BF_LAT);
  localparam int RF     = 14;

  logic       clk = 0;
  logic       reset = 1;
  logic       start = 0;
  logic       bf_enable, wr_en, busy, done;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b, stage;
  logic [2:0] tw_idx;

  int vectors = 0;
  int miscompares = 0;

  int qa[$], qb[$];
  longint qxr[$], qxi[$], qyr[$], qyi[$];
  longint mre[N], mim[N];
  longint twr[N/2], twi[N/2];

  fft_ctrl #(.N(N), .BF_LAT(BF_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .bf_enable(bf_enable),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .stage(stage), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic longint rnd(input real x);
    return (x >= 0.0) ? longint'($rtoi(x + 0.5)) : longint'($rtoi(x - 0.5));
  endfunction

  // Reference schedule: cycle c (start sampled at the end of cycle 0).
  function automatic void model(input int c, output bit iss, output int st,
                                output int a, output int b, output int tw);
    int per, idx, span;
    per = N/2 + BF_LAT;
    iss = 0; st = 0; a = 0; b = 0; tw = 0;
    if (c >= 1 && c < LAST) begin
      idx = (c - 1) % per;
      st  = (c - 1) / per;
      if (idx < N/2) begin
        iss  = 1;
        span = N >> (st + 1);
        a    = 2 * span * (idx / span) + (idx % span);
        b    = a + span;
        tw   = (idx % span) << st;
      end
    end
  endfunction

  task automatic run_seq(input int again_at, input int reset_at, input bit use_mem);
    bit iss, iss_d, aborted;
    int st, ea, eb, etw, st_d, ea_d, eb_d, etw_d;
    int wr_count, done_count, pa, pb;
    longint ar, ai, br, bi, dr, di;
    aborted = 0; wr_count = 0; done_count = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c <= LAST + 3; c++) begin
      model(c, iss, st, ea, eb, etw);
      model(c - BF_LAT, iss_d, st_d, ea_d, eb_d, etw_d);
      if (aborted) begin iss = 0; iss_d = 0; ea = 0; eb = 0; etw = 0; end
      vectors++;
      if (busy !== (!aborted && c <= LAST)) begin
        miscompares++; $display("FAIL busy cyc=%0d got=%b exp=%b", c, busy, !aborted && c <= LAST);
      end
      vectors++;
      if (done !== (!aborted && c == LAST)) begin
        miscompares++; $display("FAIL done cyc=%0d got=%b exp=%b", c, done, !aborted && c == LAST);
      end
      vectors++;
      if (bf_enable !== iss || rd_addr_a !== 4'(ea) || rd_addr_b !== 4'(eb) || tw_idx !== 3'(etw)) begin
        miscompares++;
        $display("FAIL issue cyc=%0d got en=%b a=%0d b=%0d tw=%0d exp en=%b a=%0d b=%0d tw=%0d",
                 c, bf_enable, rd_addr_a, rd_addr_b, tw_idx, iss, ea, eb, etw);
      end
      vectors++;
      if (wr_en !== iss_d) begin
        miscompares++; $display("FAIL wr_en cyc=%0d got=%b exp=%b", c, wr_en, iss_d);
      end
      if (iss) begin
        vectors++;
        if (stage !== 4'(st)) begin
          miscompares++; $display("FAIL stage cyc=%0d got=%0d exp=%0d", c, stage, st);
        end
        qa.push_back(ea); qb.push_back(eb);
      end
      if (!aborted && c == 15) begin
        vectors++;
        if (rd_addr_a !== 4'd9 || rd_addr_b !== 4'd13 || tw_idx !== 3'd2) begin
          miscompares++; $display("FAIL s1k5_rd got a=%0d b=%0d tw=%0d exp a=9 b=13 tw=2", rd_addr_a, rd_addr_b, tw_idx);
        end
      end
      if (!aborted && c == 16) begin
        vectors++;
        if (wr_addr_a !== 4'd9 || wr_addr_b !== 4'd13) begin
          miscompares++; $display("FAIL s1k5_wr got a=%0d b=%0d exp a=9 b=13", wr_addr_a, wr_addr_b);
        end
      end
      if (!aborted && c == 31) begin
        vectors++;
        if (rd_addr_a !== 4'd6 || rd_addr_b !== 4'd7 || tw_idx !== 3'd0) begin
          miscompares++; $display("FAIL s3k3_rd got a=%0d b=%0d tw=%0d exp a=6 b=7 tw=0", rd_addr_a, rd_addr_b, tw_idx);
        end
      end
      if (done) done_count++;
      if (use_mem && bf_enable) begin
        ar = mre[rd_addr_a]; ai = mim[rd_addr_a]; br = mre[rd_addr_b]; bi = mim[rd_addr_b];
        dr = ar - br; di = ai - bi;
        qxr.push_back(ar + br); qxi.push_back(ai + bi);
        qyr.push_back((dr * twr[tw_idx] - di * twi[tw_idx]) >>> RF);
        qyi.push_back((dr * twi[tw_idx] + di * twr[tw_idx]) >>> RF);
      end
      if (wr_en) begin
        wr_count++;
        vectors++;
        if (qa.size() == 0) begin
          miscompares++; $display("FAIL wr_addr cyc=%0d got a=%0d b=%0d exp none", c, wr_addr_a, wr_addr_b);
        end else begin
          pa = qa.pop_front(); pb = qb.pop_front();
          if (wr_addr_a !== 4'(pa) || wr_addr_b !== 4'(pb)) begin
            miscompares++;
            $display("FAIL wr_addr cyc=%0d got a=%0d b=%0d exp a=%0d b=%0d", c, wr_addr_a, wr_addr_b, pa, pb);
          end
        end
        if (use_mem && qxr.size() != 0) begin
          mre[wr_addr_a] = qxr.pop_front(); mim[wr_addr_a] = qxi.pop_front();
          mre[wr_addr_b] = qyr.pop_front(); mim[wr_addr_b] = qyi.pop_front();
        end
      end
      start = (c == again_at);
      reset = (c == reset_at);
      if (c == reset_at) aborted = 1;
      @(posedge clk); #1;
    end
    start = 0; reset = 0;
    vectors++;
    if (wr_count !== (aborted ? reset_at - 1 - (reset_at - 1) / (N/2 + BF_LAT) - BF_LAT + 1 : LOG2N * N/2)) begin
      miscompares++; $display("FAIL wr_count got=%0d aborted=%b", wr_count, aborted);
    end
    vectors++;
    if (done_count !== (aborted ? 0 : 1)) begin
      miscompares++; $display("FAIL done_count got=%0d exp=%0d", done_count, aborted ? 0 : 1);
    end
    qa.delete(); qb.delete(); qxr.delete(); qxi.delete(); qyr.delete(); qyi.delete();
  endtask

  task automatic test_reset();
    reset = 1; start = 1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, bf_enable, wr_en, rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b, stage} !== '0) begin
      miscompares++; $display("FAIL reset_outputs got busy=%b en=%b wr=%b stage=%0d exp all 0", busy, bf_enable, wr_en, stage);
    end
    reset = 0; start = 0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_wins got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < N; i++) begin mre[i] = 0; mim[i] = 0; end
    mre[0] = longint'(1) << RF;
    run_seq(-1, -1, 1);
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (mre[i] < (longint'(1) << RF) - 1 || mre[i] > (longint'(1) << RF) + 1 || mim[i] < -1 || mim[i] > 1) begin
        miscompares++; $display("FAIL bin%0d got re=%0d im=%0d exp re=%0d im=0", i, mre[i], mim[i], longint'(1) << RF);
      end
    end
  endtask

  task automatic test_start_ignored();
    run_seq(10, -1, 0);
  endtask

  task automatic test_reset_mid();
    run_seq(-1, 20, 0);
    run_seq(-1, -1, 0);
  endtask

  task automatic test_back_to_back();
    run_seq(LAST, -1, 0);
    run_seq(-1, -1, 0);
  endtask

  initial begin
    for (int t = 0; t < N/2; t++) begin
      twr[t] = rnd($cos(2.0 * 3.14159265358979 * t / N) * (1 << RF));
      twi[t] = rnd(-$sin(2.0 * 3.14159265358979 * t / N) * (1 << RF));
    end
    test_reset();
    test_impulse();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, FFT points (power of two, 4..256).
REQ-002 SHALL have parameter BF_LAT, default 1, butterfly register latency in cycles (1..4).
REQ-003 SHALL derive localparam LOG2N = log2(N); AW = LOG2N address width.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle request to run a full N-point DIF FFT.
REQ-007 SHALL have port bf_enable  out  1  drives butterfly enable; high only on issue cycles.
REQ-008 SHALL have ports rd_addr_a / rd_addr_b  out  AW each  operand A/B read addresses into the in-place sample memory (combinational read).
REQ-009 SHALL have port tw_idx  out  LOG2N-1  twiddle ROM index, W_N^tw_idx.
REQ-010 SHALL have port wr_en  out  1  write-back strobe for butterfly X/Y.
REQ-011 SHALL have ports wr_addr_a / wr_addr_b  out  AW each  write addresses for X/Y.
REQ-012 SHALL have port stage  out  LOG2N bits  current stage number.
REQ-013 SHALL have ports busy  out  1  and done  out  1  (done is a one-cycle pulse).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE -> RUN on start=1; stage=0, butterfly counter k=0 on entry.
REQ-016 In RUN, each cycle issues one butterfly: bf_enable=1, k increments by 1.
REQ-017 Addressing per stage s: span = N>>(s+1); g = k/span; j = k%span; rd_addr_a = 2*span*g + j; rd_addr_b = rd_addr_a + span; tw_idx = j<<s.
REQ-018 RUN -> DRAIN after issuing k = N/2-1; DRAIN lasts exactly BF_LAT cycles with bf_enable=0 and no reads.
REQ-019 DRAIN -> RUN with stage+1, k=0 when stage < LOG2N-1; else DRAIN -> DONE.
REQ-020 DONE SHALL assert done=1 for one cycle, then -> IDLE.
REQ-021 wr_en, wr_addr_a, wr_addr_b SHALL equal bf_enable, rd_addr_a, rd_addr_b delayed by exactly BF_LAT cycles via a shift-register pipeline.
REQ-022 busy SHALL be 1 in RUN, DRAIN, DONE; 0 in IDLE.
REQ-023 start while busy=1 SHALL be ignored (no restart, no queueing).
REQ-024 Total latency start-to-done SHALL be 1 + LOG2N*(N/2 + BF_LAT) cycles; N=16, BF_LAT=1: 37.
REQ-025 No read of stage s+1 SHALL occur in a cycle before the final write of stage s (guaranteed by DRAIN).
REQ-026 In IDLE, DRAIN, DONE, rd_addr_a/rd_addr_b/tw_idx SHALL be driven 0.
REQ-027 Counters SHALL not wrap: k bounded to N/2-1, stage bounded to LOG2N-1.

Reset
REQ-028 reset=1 SHALL force IDLE, k=0, stage=0, clear write pipeline; all outputs 0 next cycle.
REQ-029 reset mid-operation SHALL abort with no further wr_en pulses and no done pulse.
REQ-030 reset and start in the same cycle: reset SHALL win.

Structure
REQ-031 FFT_N and FFT_LOG2N constants SHALL live in the shared fixed-point package alongside complex_product_t, R, FIXED_POINT_MAX/MIN; state enum local to module.
REQ-032 Address/twiddle math (REQ-017) SHALL be one combinational sub-module fft_addr_gen (inputs stage, k; outputs addr_a, addr_b, tw_idx).

Verification
REQ-033 N=16, BF_LAT=1, start pulse -> done at cycle 37, busy high cycles 1..37, exactly 32 wr_en pulses.
REQ-034 Stage 0 k=0..7 -> (a,b,tw) = (0,8,0),(1,9,1)..(7,15,7); stage 3 k=3 -> (6,7,0).
REQ-035 Stage 1 k=5 -> a=9, b=13, tw=2; wr_addr_a=9, wr_addr_b=13 exactly one cycle later.
REQ-036 start re-asserted at cycle 10 -> ignored, done still at 37 only.
REQ-037 reset at cycle 20 -> next cycle busy=0, wr_en=0, no done; new start runs full 37-cycle sequence.
REQ-038 Full loop with butterfly and memory model: impulse x[0]=1.0 -> all 16 bins equal (bit-reversed order) within 1 LSB.
